// File: rtl/interp_sequencer_if.sv
// interp_sequencer_if
// Bundles every non-clock signal of the STFT interpolation sequencer.
//
// Parameter:
//   ADDR_W  bin address width
//
// Modports:
//   master : the sequencer side
//            drives busy, done, rd_en, rd_addr, xf_en,
//            out_valid, out_coeff, out_bin, out_phase
//   slave  : the environment side
//            buffers, interpolator, downstream stage and start source
//
// Signals:
//   start              one-cycle sequence start pulse
//   busy               sequencer not idle
//   done               one-cycle pulse after the final handshake
//   rd_en / rd_addr    read strobe and bin address to both buffer units
//   master_coeff       older-frame coefficient, valid the cycle after rd_en
//   slave_coeff        newer-frame coefficient, valid the cycle after rd_en
//   xf_en              interpolator enable
//   xf_quarter         (master+3*slave)>>2
//   xf_half            (master+slave)>>1
//   xf_three_quarters  (3*master+slave)>>2
//   out_valid / out_ready  output handshake
//   out_coeff / out_bin / out_phase  output payload
interface interp_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [27:0]       slave_coeff;
  logic [27:0]       master_coeff;
  logic              xf_en;
  logic [27:0]       xf_quarter;
  logic [27:0]       xf_half;
  logic [27:0]       xf_three_quarters;
  logic              out_valid;
  logic              out_ready;
  logic [27:0]       out_coeff;
  logic [ADDR_W-1:0] out_bin;
  logic [2:0]        out_phase;

  modport master (
    input  start, slave_coeff, master_coeff,
           xf_quarter, xf_half, xf_three_quarters, out_ready,
    output busy, done, rd_en, rd_addr, xf_en,
           out_valid, out_coeff, out_bin, out_phase
  );

  modport slave (
    output start, slave_coeff, master_coeff,
           xf_quarter, xf_half, xf_three_quarters, out_ready,
    input  busy, done, rd_en, rd_addr, xf_en,
           out_valid, out_coeff, out_bin, out_phase
  );
endinterface

// File: rtl/interp_sequencer.sv
// interp_sequencer
// Sequences the STFT coefficient interpolation datapath.
// A start pulse walks every bin of the master and slave coefficient buffers
// once per phase. Each phase selects one interpolated frame. Frames are
// streamed oldest to newest through a valid/ready output.
//
// Parameters:
//   NUM_BINS  bins per frame, >= 2
//   ADDR_W    bin address width, 2**ADDR_W >= NUM_BINS
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  interp_sequencer_if.master
//        start/busy/done, buffer read, interpolator and output stream
//
// Optional build macro:
//   INTERP_ENDPOINTS_EN
//     When defined, a leading master_coeff phase is added, giving 5 phases.
//     When undefined, the default build has 4 phases:
//     three_quarters, half, quarter, slave.
module interp_sequencer #(
  parameter int NUM_BINS = 256,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  interp_sequencer_if.master  bus
);

`ifdef INTERP_ENDPOINTS_EN
  localparam int NUM_PHASES = 5;
`else
  localparam int NUM_PHASES = 4;
`endif

  localparam logic [2:0]        LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [ADDR_W-1:0] LAST_BIN   = ADDR_W'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_OUT,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] bin;
  logic [2:0]        phase;
  logic [27:0]       coeff_sel;
  logic [27:0]       out_coeff_q;
  logic [ADDR_W-1:0] out_bin_q;
  logic [2:0]        out_phase_q;
  logic              handshake;
  logic              last_bin;
  logic              last_phase;

  assign handshake  = (state == S_OUT) && bus.out_ready;
  assign last_bin   = (bin == LAST_BIN);
  assign last_phase = (phase == LAST_PHASE);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs.
  // The control outputs are decoded from the state alone, so a reset that
  // forces IDLE also zeroes every strobe at once.
  // NOTE: every signal gets a default before the case statement. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    bus.busy      = (state != S_IDLE);
    bus.done      = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.xf_en     = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_next = S_READ;
      end
      S_READ: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = bin;
        state_next  = S_LATCH;
      end
      S_LATCH: begin
        bus.xf_en  = 1'b1;
        state_next = S_OUT;
      end
      S_OUT: begin
        bus.xf_en     = 1'b1;
        bus.out_valid = 1'b1;
        if (handshake) state_next = (last_bin && last_phase) ? S_DONE : S_READ;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Phase-to-source selection. Phases run from the oldest frame to the newest.
  always_comb begin
    coeff_sel = '0;
`ifdef INTERP_ENDPOINTS_EN
    case (phase)
      3'd0:    coeff_sel = bus.master_coeff;
      3'd1:    coeff_sel = bus.xf_three_quarters;
      3'd2:    coeff_sel = bus.xf_half;
      3'd3:    coeff_sel = bus.xf_quarter;
      3'd4:    coeff_sel = bus.slave_coeff;
      default: coeff_sel = '0;
    endcase
`else
    case (phase)
      3'd0:    coeff_sel = bus.xf_three_quarters;
      3'd1:    coeff_sel = bus.xf_half;
      3'd2:    coeff_sel = bus.xf_quarter;
      3'd3:    coeff_sel = bus.slave_coeff;
      default: coeff_sel = '0;
    endcase
`endif
  end

  // Bin/phase counters and the output payload register.
  // Buffer data arrives the cycle after READ, so the payload is captured in
  // LATCH. The payload is only reloaded in LATCH, which keeps it stable for
  // the whole time it waits in OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin         <= '0;
      phase       <= '0;
      out_coeff_q <= '0;
      out_bin_q   <= '0;
      out_phase_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            bin   <= '0;
            phase <= '0;
          end
        end
        S_LATCH: begin
          out_coeff_q <= coeff_sel;
          out_bin_q   <= bin;
          out_phase_q <= phase;
        end
        S_OUT: begin
          if (handshake) begin
            if (!last_bin) begin
              bin <= bin + 1'b1;
            end else if (!last_phase) begin
              // The bin counter wraps only here, so it never addresses a bin
              // at or above NUM_BINS.
              bin   <= '0;
              phase <= phase + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_coeff = out_coeff_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_phase = out_phase_q;

endmodule

// File: tb/tb_interp_sequencer.sv
// tb_interp_sequencer
// Self-checking bench for interp_sequencer with NUM_BINS=4.
//
// Environment models:
//   - coefficient buffers with a one-cycle registered read
//   - a combinational interpolator
//
// Reference:
//   A queue of expected (phase, bin, value) outputs, built from a
//   crossfade-weight formula.
//
// Build macro:
//   INTERP_ENDPOINTS_EN selects the 5-phase build, as in the RTL.
module tb_interp_sequencer;

  localparam int NB     = 4;
  localparam int ADDR_W = 8;
`ifdef INTERP_ENDPOINTS_EN
  localparam int NP = 5;
`else
  localparam int NP = 4;
`endif
  localparam int TOTAL = NP * NB;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  interp_sequencer_if #(.ADDR_W(ADDR_W)) ifc ();

  interp_sequencer #(.NUM_BINS(NB), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Buffer contents, indexed by bin.
  logic [27:0] m_mem [NB];
  logic [27:0] s_mem [NB];

  // Buffer units: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (ifc.rd_en) begin
      ifc.master_coeff <= m_mem[ifc.rd_addr[1:0]];
      ifc.slave_coeff  <= s_mem[ifc.rd_addr[1:0]];
    end
  end

  // Interpolator model attached to the buffer outputs.
  assign ifc.xf_quarter        = 28'((30'(ifc.master_coeff) + 30'(3) * 30'(ifc.slave_coeff)) >> 2);
  assign ifc.xf_half           = 28'((30'(ifc.master_coeff) + 30'(ifc.slave_coeff)) >> 1);
  assign ifc.xf_three_quarters = 28'((30'(3) * 30'(ifc.master_coeff) + 30'(ifc.slave_coeff)) >> 2);

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [38:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  // Phase p blends in w quarters of the slave frame, where w = p+1 in the
  // 4-phase build and w = p in the 5-phase build. The result is truncated.
  task automatic build_expected();
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < NB; b++) begin
        longint w, v;
        w = (NP == 5) ? longint'(p) : longint'(p + 1);
        v = ((4 - w) * longint'(m_mem[b]) + w * longint'(s_mem[b])) / 4;
        exp_q.push_back({3'(p), 8'(b), 28'(v)});
      end
    end
  endtask

  // Output monitor. It samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.rd_en) begin
        check("rd_addr_range", 64'(ifc.rd_addr < ADDR_W'(NB)), 64'd1);
        check("xf_en_read", 64'(ifc.xf_en), 64'd0);
      end
      if (ifc.out_valid) check("xf_en_out", 64'(ifc.xf_en), 64'd1);
      if (ifc.done) done_cnt++;
      if (ifc.out_valid && ifc.out_ready) begin
        hs_cnt++;
        if (exp_q.size() != 0)
          check("out_payload", 64'({ifc.out_phase, ifc.out_bin, ifc.out_coeff}), 64'(exp_q.pop_front()));
        else
          check("hs_extra", 64'(hs_cnt), 64'(TOTAL));
      end
    end
  end

  task automatic fill(input int mode, input logic [27:0] m, input logic [27:0] s);
    for (int b = 0; b < NB; b++) begin
      m_mem[b] = (mode == 0) ? m : 28'($urandom);
      s_mem[b] = (mode == 0) ? s : 28'($urandom);
    end
  endtask

  // Pulses start and checks the start-to-first-out_valid latency.
  task automatic kick();
    int n;
    hs_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    n = 1;
    while (!ifc.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'd3);
  endtask

  task automatic end_checks(input bit start_at_done);
    // Entered #1 after the edge that made done visible.
    if (start_at_done) ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    check("start_at_done_ignored", 64'(ifc.busy), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("hs_count", 64'(hs_cnt), 64'(TOTAL));
    check("done_count", 64'(done_cnt), 64'd1);
    check("exp_left", 64'(exp_q.size()), 64'd0);
    check("idle_busy", 64'(ifc.busy), 64'd0);
  endtask

  task automatic run_seq(input bit rnd_ready, input bit rnd_start, input bit start_at_done);
    bit seen = 1'b0;
    build_expected();
    ifc.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    kick();
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk); #1;
      ifc.start = 1'b0;
      if (ifc.done) begin
        seen = 1'b1;
      end else begin
        if (rnd_ready) ifc.out_ready = ($urandom_range(0, 3) != 0);
        if (rnd_start) ifc.start = ($urandom_range(0, 15) == 0);
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    end_checks(start_at_done);
  endtask

  initial begin
    bit held;
    bit seen;
    logic [38:0] snap;

    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.master_coeff = '0;
    ifc.slave_coeff = '0;
    fill(0, 28'd0, 28'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({ifc.busy, ifc.done, ifc.rd_en, ifc.xf_en, ifc.out_valid,
               ifc.rd_addr, ifc.out_coeff, ifc.out_bin, ifc.out_phase}), 64'd0);
    rst = 1'b0;

    // Ordering with constant frames.
    fill(0, 28'd100, 28'd200);
    run_seq(1'b0, 1'b0, 1'b0);

    // Truncation and extremes.
    fill(0, 28'd1, 28'd2);
    run_seq(1'b0, 1'b0, 1'b0);
    fill(0, 28'hFFFFFFF, 28'hFFFFFFF);
    run_seq(1'b0, 1'b0, 1'b0);

    // Backpressure at bin 2 of phase 1.
    fill(1, '0, '0);
    build_expected();
    ifc.out_ready = 1'b0;
    held = 1'b0;
    seen = 1'b0;
    kick();
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk); #1;
      ifc.out_ready = 1'b0;
      if (ifc.done) begin
        seen = 1'b1;
      end else if (ifc.out_valid) begin
        if (!held && ifc.out_bin == 8'd2 && ifc.out_phase == 3'd1) begin
          snap = {ifc.out_phase, ifc.out_bin, ifc.out_coeff};
          repeat (10) begin
            @(posedge clk); #1;
            check("bp_valid", 64'(ifc.out_valid), 64'd1);
            check("bp_stable", 64'({ifc.out_phase, ifc.out_bin, ifc.out_coeff}), 64'(snap));
            check("bp_no_read", 64'(ifc.rd_en), 64'd0);
          end
          held = 1'b1;
        end
        ifc.out_ready = 1'b1;
      end
    end
    check("bp_done_seen", 64'(seen), 64'd1);
    check("bp_hold_reached", 64'(held), 64'd1);
    end_checks(1'b0);

    // Random data, random backpressure and stray start pulses while busy.
    for (int i = 0; i < 3; i++) begin
      fill(1, '0, '0);
      run_seq(1'b1, 1'b1, i == 2);
    end

    // Reset during a phase-2 OUT, then a fresh sequence.
    fill(1, '0, '0);
    build_expected();
    ifc.out_ready = 1'b1;
    kick();
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(posedge clk); #1;
      if (ifc.out_valid && ifc.out_phase == 3'd2) seen = 1'b1;
    end
    check("rst_point_reached", 64'(seen), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_outputs",
          64'({ifc.busy, ifc.done, ifc.rd_en, ifc.xf_en, ifc.out_valid,
               ifc.rd_addr, ifc.out_coeff, ifc.out_bin, ifc.out_phase}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_idle", 64'(ifc.busy), 64'd0);
    fill(1, '0, '0);
    run_seq(1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interp_sequencer.md
Name: interp_sequencer

Overview:
- Controller that sequences the STFT coefficient interpolation datapath.
- On `start`, walks every frequency bin of the master (older) and slave (newer) coefficient buffers and drives the external interpolator.
- Streams interpolated frames, ordered oldest to newest, through a valid/ready output.
- Sits between the coefficient buffer units and the downstream synthesis stage.

Parameters:
- NUM_BINS, 256: coefficients per buffer (bins per frame); must be >= 2.
- ADDR_W, 8: bin address width; must satisfy 2^ADDR_W >= NUM_BINS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a sequence; ignored unless idle
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse after the final coefficient handshake
- rd_en  output  1  read strobe to both buffer units
- rd_addr  output  ADDR_W  bin address to both buffer units
- slave_coeff  input  28  slave buffer data, valid the cycle after rd_en
- master_coeff  input  28  master buffer data, valid the cycle after rd_en
- xf_en  output  1  interpolator enable
- xf_quarter  input  28  (master+3*slave)>>2 from the interpolator
- xf_half  input  28  (master+slave)>>1
- xf_three_quarters  input  28  (3*master+slave)>>2
- out_valid  output  1  output coefficient valid
- out_ready  input  1  downstream accept
- out_coeff  output  28  selected coefficient
- out_bin  output  ADDR_W  bin index of out_coeff
- out_phase  output  3  frame index within the sequence

Behaviour:
- Reset (async, rst=1), all outputs 0:
  - state=IDLE; bin counter=0; phase=first phase.
  - busy, done, rd_en, xf_en, out_valid = 0.
  - rd_addr, out_coeff, out_bin, out_phase = 0.
- Phase order without the optional feature, 4 phases:
  - 0 = xf_three_quarters
  - 1 = xf_half
  - 2 = xf_quarter
  - 3 = slave_coeff
- States:
  - IDLE: on start, go to READ with bin=0, phase=first.
  - READ: rd_en=1, rd_addr=bin for exactly one cycle; go to LATCH.
  - LATCH: xf_en=1. Register the coefficient selected by phase into out_coeff, out_bin=bin, out_phase=phase; go to OUT.
  - OUT: out_valid=1. out_coeff, out_bin and out_phase stay stable until out_valid && out_ready. On handshake:
    - not last bin: bin+1, go to READ.
    - last bin, not last phase: bin=0, phase+1, go to READ.
    - last bin, last phase: go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- xf_en is also held high in OUT. It is 0 in IDLE, READ and DONE.
- Latency: start to first out_valid is 3 cycles. Each coefficient takes 3 cycles minimum with out_ready tied high.
- out_valid is never deasserted without a handshake.
- Boundaries:
  - start while busy: ignored, no restart.
  - out_ready held low: remains in OUT indefinitely, no further reads.
  - Bin counter wraps from NUM_BINS-1 to 0 only on a phase advance. It never addresses bins >= NUM_BINS.
  - rst mid-sequence: immediately returns to IDLE with the reset values above. No done pulse. Partial output is discarded.
  - start in the same cycle as the DONE→IDLE transition: ignored, because the state is not yet IDLE.
- The block performs no arithmetic on coefficients. out_coeff is a pure registered 28-bit selection of the chosen input.

Optional Feature:
- Macro: INTERP_ENDPOINTS_EN.
- Defined: 5 phases. Phase 0 = master_coeff, then 1 = three_quarters, 2 = half, 3 = quarter, 4 = slave_coeff. This gives a complete master-to-slave crossfade including the older endpoint. Total handshakes = 5*NUM_BINS.
- Undefined: 4 phases as listed under Behaviour. Total handshakes = 4*NUM_BINS. out_phase never exceeds 3.

Test Plan:
- Ordering: NUM_BINS=4, master=100 and slave=200 at every bin, model interpolator attached, out_ready=1, pulse start.
  - Expect 16 outputs: bins 0..3 of 125, then 150, then 175, then 200.
  - out_phase 0..3; done pulses once after the 16th handshake; first out_valid 3 cycles after start.
- Truncation and extremes:
  - master=1, slave=2 → 1, 1, 1, 2.
  - master=slave=28'hFFFFFFF → 28'hFFFFFFF for every phase.
- Backpressure: hold out_ready=0 for 10 cycles at bin 2 of phase 1.
  - out_valid stays 1 and out_coeff/out_bin/out_phase stay stable.
  - No rd_en pulses; sequence resumes correctly when ready rises.
- Start while busy: pulse start again mid-sequence → no restart; output count stays 4*NUM_BINS; a single done pulse.
- Reset mid-operation: assert rst during phase 2 OUT → outputs immediately zero, busy=0, no done. A fresh start then produces a full, correct sequence.
- INTERP_ENDPOINTS_EN defined: same stimulus as the ordering test → 20 outputs, phases 0..4 with values 100, 125, 150, 175, 200.
